// File: rtl/pmic_glitch_sequencer_pkg.sv
// Shared definitions for the PMIC glitch sequencer: FSM encodings,
// instruction field layout and the chain-continuation decode.
package pmic_glitch_sequencer_pkg;

    localparam int INSTR_W     = 12;
    localparam int DATA_W      = 9;
    localparam int BUS_SEL_BIT = 9;
    localparam int DAC_BIT     = 10;
    localparam int DELAY_BIT   = 11;

    typedef enum logic [3:0] {
        S_INIT        = 4'd0,
        S_LOAD_INSTR  = 4'd1,
        S_I2C_WAIT    = 4'd2,
        S_I2C_CHECK   = 4'd3,
        S_DAC_UPDATE  = 4'd4,
        S_DELAY       = 4'd5,
        S_PREP_DELAY  = 4'd6,
        S_DEPTH_CLEAR = 4'd7,
        S_NEW_PARCEL  = 4'd9,
        S_PTR_DEC     = 4'd10
    } state_e;

    // After a DAC write or a finished delay: keep chaining, or end the parcel.
    function automatic state_e chain_next(input logic [INSTR_W-1:0] instr);
        if (instr[DELAY_BIT])
            return S_PREP_DELAY;
        else if (instr[DAC_BIT])
            return S_DAC_UPDATE;
        else
            return S_PTR_DEC;
    endfunction

endpackage

// File: rtl/pmic_glitch_sequencer_updown_counter.sv
// Wrapping up/down counter with a priority load used as a clear.
module updown_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = load_val_i;
        else if (inc_i && !dec_i)
            count_d = count_q + WIDTH'(1);
        else if (dec_i && !inc_i)
            count_d = count_q - WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pmic_glitch_sequencer.sv
// Programmable 1.2 V control path: matches I2C word sequences from a ROM
// program, then drives a chain of DAC writes and timed delays.
module pmic_glitch_sequencer
    import pmic_glitch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DELAY_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:0]         i2c_main_i,
    input  logic               main_ready_i,
    input  logic [8:0]         i2c_priv_i,
    input  logic               priv_ready_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [INSTR_W-1:0] rom_instr_i,
    output logic [7:0]         rom_delay_idx_o,
    input  logic [DELAY_W-1:0] rom_delay_i,
    output logic [7:0]         dac_out_o,
    output logic [3:0]         state_o,
    output logic [DELAY_W-1:0] delay_count_o
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    parcel_start_q, parcel_start_d;
    logic [INSTR_W-1:0]   parcel_instr_q, parcel_instr_d;
    logic [INSTR_W-1:0]   curr_q, curr_d;
    logic [DELAY_W-1:0]   delay_len_q, delay_len_d;
    logic [7:0]           dac_q, dac_d;

    logic [ADDR_W-1:0]    depth;
    logic                 depth_inc, depth_dec, depth_clr;
    logic [DELAY_W-1:0]   delay_count;
    logic                 dly_inc, dly_clr;
    logic [DELAY_W-1:0]   dly_load;

    logic                 sel_ready;
    logic [DATA_W-1:0]    sel_word;
    logic                 delay_done;

    assign sel_ready  = curr_q[BUS_SEL_BIT] ? priv_ready_i : main_ready_i;
    assign sel_word   = curr_q[BUS_SEL_BIT] ? i2c_priv_i   : i2c_main_i;
    assign delay_done = delay_count > delay_len_q;

    assign rom_addr_o      = parcel_start_q + depth;
    assign rom_delay_idx_o = (state_q == S_PREP_DELAY) ? curr_q[8:1] : 8'd0;
    assign dac_out_o       = dac_q;
    assign state_o         = state_q;
    assign delay_count_o   = delay_count;

    // The delay counter runs only in DELAY; INIT parks it at all-ones.
    assign dly_inc  = (state_q == S_DELAY);
    assign dly_clr  = (state_q != S_DELAY);
    assign dly_load = (state_q == S_INIT) ? {DELAY_W{1'b1}} : '0;

    updown_counter #(.WIDTH(ADDR_W)) u_depth (
        .clk        (clk),
        .inc_i      (depth_inc),
        .dec_i      (depth_dec),
        .clr_i      (depth_clr),
        .load_val_i ('0),
        .count_o    (depth)
    );

    updown_counter #(.WIDTH(DELAY_W)) u_delay (
        .clk        (clk),
        .inc_i      (dly_inc),
        .dec_i      (1'b0),
        .clr_i      (dly_clr),
        .load_val_i (dly_load),
        .count_o    (delay_count)
    );

    always_comb begin
        state_d        = state_q;
        parcel_start_d = parcel_start_q;
        parcel_instr_d = parcel_instr_q;
        curr_d         = curr_q;
        delay_len_d    = delay_len_q;
        dac_d          = dac_q;
        depth_inc      = 1'b0;
        depth_dec      = 1'b0;
        depth_clr      = 1'b0;

        case (state_q)
            S_INIT: begin
                parcel_start_d = '0;
                parcel_instr_d = '0;
                curr_d         = '0;
                delay_len_d    = '0;
                dac_d          = '0;
                depth_clr      = 1'b1;
                state_d        = S_NEW_PARCEL;
            end
            S_NEW_PARCEL: begin
                parcel_start_d = rom_addr_o;
                parcel_instr_d = rom_instr_i;
                depth_clr      = 1'b1;
                state_d        = S_LOAD_INSTR;
            end
            S_LOAD_INSTR: begin
                curr_d    = parcel_instr_q;
                depth_inc = 1'b1;
                if (rom_instr_i[DELAY_BIT])
                    state_d = S_PREP_DELAY;
                else if (rom_instr_i[DAC_BIT])
                    state_d = S_DAC_UPDATE;
                else
                    state_d = S_I2C_WAIT;
            end
            S_I2C_WAIT: begin
                if (sel_ready)
                    state_d = S_I2C_CHECK;
            end
            S_I2C_CHECK: begin
                depth_inc = 1'b1;
                if (sel_word == curr_q[DATA_W-1:0]) begin
                    curr_d = rom_instr_i;
                    // DAC wins over delay straight after a match.
                    if (rom_instr_i[DAC_BIT])
                        state_d = S_DAC_UPDATE;
                    else if (rom_instr_i[DELAY_BIT])
                        state_d = S_PREP_DELAY;
                    else
                        state_d = S_I2C_WAIT;
                end else begin
                    state_d = S_DEPTH_CLEAR;
                end
            end
            S_DEPTH_CLEAR: begin
                depth_clr = 1'b1;
                state_d   = S_LOAD_INSTR;
            end
            S_DAC_UPDATE: begin
                dac_d     = curr_q[8:1];
                curr_d    = rom_instr_i;
                depth_inc = 1'b1;
                state_d   = chain_next(rom_instr_i);
            end
            S_PREP_DELAY: begin
                delay_len_d = rom_delay_i;
                state_d     = S_DELAY;
            end
            S_DELAY: begin
                if (delay_done) begin
                    curr_d    = rom_instr_i;
                    depth_inc = 1'b1;
                    state_d   = chain_next(rom_instr_i);
                end
            end
            S_PTR_DEC: begin
                // Step back so the chain-ending instruction opens the next parcel.
                depth_dec = 1'b1;
                state_d   = S_NEW_PARCEL;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            dac_q   <= '0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
        end
    end

    always_ff @(posedge clk) begin
        parcel_start_q <= parcel_start_d;
        parcel_instr_q <= parcel_instr_d;
        curr_q         <= curr_d;
        delay_len_q    <= delay_len_d;
    end

endmodule

// File: tb/tb_pmic_glitch_sequencer.sv
// Scoreboard bench for pmic_glitch_sequencer: directed traces push expected
// per-cycle observations; a negedge monitor pops and compares them.
module tb_pmic_glitch_sequencer;

    localparam longint X    = -1;
    localparam longint ONES = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  i2c_main, i2c_priv;
    logic        main_ready, priv_ready;
    logic [7:0]  rom_addr;
    logic [11:0] rom_instr;
    logic [7:0]  rom_delay_idx;
    logic [31:0] rom_delay;
    logic [7:0]  dac_out;
    logic [3:0]  state;
    logic [31:0] delay_count;

    logic [11:0] rom [256];
    logic [31:0] dly [256];

    assign rom_instr = rom[rom_addr];
    assign rom_delay = dly[rom_delay_idx];

    always #5 clk = ~clk;

    pmic_glitch_sequencer #(.ADDR_W(8), .DELAY_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .i2c_main_i      (i2c_main),
        .main_ready_i    (main_ready),
        .i2c_priv_i      (i2c_priv),
        .priv_ready_i    (priv_ready),
        .rom_addr_o      (rom_addr),
        .rom_instr_i     (rom_instr),
        .rom_delay_idx_o (rom_delay_idx),
        .rom_delay_i     (rom_delay),
        .dac_out_o       (dac_out),
        .state_o         (state),
        .delay_count_o   (delay_count)
    );

    typedef struct {
        string  tag;
        longint st;
        longint dac;
        longint addr;
        longint idx;
        longint dcnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input string what, input longint act, input longint exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "state",     longint'(state),         e.st);
            chk(e.tag, "dac_out",   longint'(dac_out),       e.dac);
            chk(e.tag, "rom_addr",  longint'(rom_addr),      e.addr);
            chk(e.tag, "delay_idx", longint'(rom_delay_idx), e.idx);
            chk(e.tag, "delay_cnt", longint'(delay_count),   e.dcnt);
        end
    end

    // Advance one clock and queue what the DUT must show after that edge.
    task automatic step(input string tag, input longint st, input longint dac,
                        input longint addr, input longint idx, input longint dcnt);
        exp_t e;
        @(posedge clk);
        #1;
        e.tag = tag; e.st = st; e.dac = dac; e.addr = addr; e.idx = idx; e.dcnt = dcnt;
        sb.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dly[i] = 32'(i + 100);
        dly[5] = 32'd3;
        reset = 1'b1; i2c_main = '0; i2c_priv = '0; main_ready = 1'b0; priv_ready = 1'b0;

        // Mismatch loop, then match and DAC, then a mismatch keeping the DAC code.
        clear_rom();
        rom[0] = 12'h0A5; rom[1] = 12'h47E; rom[2] = 12'h000;
        step("A0", 0, 0, X, X, X);
        reset = 1'b0; i2c_main = 9'h0A4; main_ready = 1'b1;
        step("A1", 9, 0, 0, 0, ONES);
        step("A2", 1, 0, 0, 0, 0);
        step("A3", 2, 0, 1, 0, 0);
        step("A4", 3, 0, 1, 0, 0);
        step("A5", 7, 0, 2, 0, 0);
        step("A6", 1, 0, 0, 0, 0);
        step("A7", 2, 0, 1, 0, 0);
        i2c_main = 9'h0A5;
        step("A8", 3, 0, 1, 0, 0);
        step("A9", 4, 0, 2, 0, 0);
        step("A10", 10, 8'h3F, 3, 0, 0);
        step("A11", 9, 8'h3F, 2, 0, 0);
        step("A12", 1, 8'h3F, 2, 0, 0);
        step("A13", 2, 8'h3F, 3, 0, 0);
        step("A14", 3, 8'h3F, 3, 0, 0);
        step("A15", 7, 8'h3F, 4, 0, 0);
        step("A16", 1, 8'h3F, 2, 0, 0);
        step("A17", 2, 8'h3F, 3, 0, 0);

        // Private bus: main is ready with a wrong word and must be ignored.
        reset = 1'b1;
        clear_rom();
        rom[0] = 12'h2A5; rom[1] = 12'h47E; rom[2] = 12'h000;
        i2c_main = 9'h0A4; main_ready = 1'b1; i2c_priv = 9'h0A5; priv_ready = 1'b0;
        step("B0", 0, 0, X, X, X);
        reset = 1'b0;
        step("B1", 9, 0, 0, 0, ONES);
        step("B2", 1, 0, 0, 0, 0);
        step("B3", 2, 0, 1, 0, 0);
        step("B4", 2, 0, 1, 0, 0);
        step("B5", 2, 0, 1, 0, 0);
        priv_ready = 1'b1;
        step("B6", 3, 0, 1, 0, 0);
        priv_ready = 1'b0;
        step("B7", 4, 0, 2, 0, 0);
        step("B8", 10, 8'h3F, 3, 0, 0);

        // Delay of table[5]=3 then a DAC write; second parcel interrupted by reset.
        reset = 1'b1;
        clear_rom();
        rom[0] = 12'h0A5; rom[1] = 12'h80A; rom[2] = 12'h47E;
        rom[3] = 12'h0A5; rom[4] = 12'h80A;
        i2c_main = 9'h0A5; main_ready = 1'b1; i2c_priv = '0; priv_ready = 1'b0;
        step("C0", 0, 0, X, X, X);
        reset = 1'b0;
        step("C1", 9, 0, 0, 0, ONES);
        step("C2", 1, 0, 0, 0, 0);
        step("C3", 2, 0, 1, 0, 0);
        step("C4", 3, 0, 1, 0, 0);
        step("C5", 6, 0, 2, 5, 0);
        step("C6", 5, 0, 2, 0, 0);
        step("C7", 5, 0, 2, 0, 1);
        step("C8", 5, 0, 2, 0, 2);
        step("C9", 5, 0, 2, 0, 3);
        step("C10", 5, 0, 2, 0, 4);
        step("C11", 4, 0, 3, 0, 5);
        step("C12", 10, 8'h3F, 4, 0, 0);
        step("C13", 9, 8'h3F, 3, 0, 0);
        step("C14", 1, 8'h3F, 3, 0, 0);
        step("C15", 2, 8'h3F, 4, 0, 0);
        step("C16", 3, 8'h3F, 4, 0, 0);
        step("C17", 6, 8'h3F, 5, 5, 0);
        step("C18", 5, 8'h3F, 5, 0, 0);
        step("C19", 5, 8'h3F, 5, 0, 1);
        reset = 1'b1;
        step("C20", 0, 0, X, X, X);
        reset = 1'b0;
        step("C21", 9, 0, 0, 0, ONES);
        step("C22", 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
